// File: rtl/ram_arbiter_pkg.sv
// Shared types for the program-RAM arbiter: FSM state encoding, owner codes
// and the state-to-owner decode used on the owner output.
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      S_CPU      = 2'd0,
      S_BOOT_WR  = 2'd1,
      S_DBG_ADDR = 2'd2,
      S_DBG_DATA = 2'd3
   } state_t;

   localparam logic [1:0] OWN_CPU  = 2'd0;
   localparam logic [1:0] OWN_BOOT = 2'd1;
   localparam logic [1:0] OWN_DBG  = 2'd2;

   // Which requester was granted most recently; breaks boot/debug ties.
   localparam logic GRANT_BOOT = 1'b0;
   localparam logic GRANT_DBG  = 1'b1;

   function automatic logic [1:0] owner_of(input state_t s);
      logic [1:0] o;
      case (s)
         S_BOOT_WR:              o = OWN_BOOT;
         S_DBG_ADDR, S_DBG_DATA: o = OWN_DBG;
         default:                o = OWN_CPU;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Single-clock arbiter sharing the program RAM between CPU, UART bootloader
// (boot-mode writes) and a debug reader; stalls the CPU and preserves its in-flight read.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_en,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              boot_req,
   input  logic [15:0]       boot_addr,
   input  logic [DATA_W-1:0] boot_wdata,
   output logic              boot_ack,
   input  logic              dbg_req,
   input  logic [15:0]       dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        owner,
   output logic [15:0]       boot_wr_count
);

   state_t              state;
   state_t              next_state;
   state_t              state_eff;
   logic                last_grant;
   logic                next_last_grant;
   logic                was_cpu;
   logic                hold_valid;
   logic [DATA_W-1:0]   hold_reg;
   logic                boot_pending;
   logic                dbg_pending;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{cpu_addr[15:ADDR_W], boot_addr[15:ADDR_W], dbg_addr[15:ADDR_W]};

   // While reset is asserted the port behaves as CPU-owned, so an abandoned
   // boot write can never reach the RAM on the reset edge.
   assign state_eff = rst_n ? state : S_CPU;

   assign boot_pending = boot_en && boot_req && !boot_ack;
   assign dbg_pending  = dbg_req && !dbg_ack;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_CPU;
         last_grant <= GRANT_DBG;
      end else begin
         state      <= next_state;
         last_grant <= next_last_grant;
      end
   end

   always_comb begin
      next_state      = state_eff;
      next_last_grant = last_grant;
      case (state_eff)
         S_CPU: begin
            if (boot_pending && (!dbg_pending || last_grant == GRANT_DBG)) begin
               next_state      = S_BOOT_WR;
               next_last_grant = GRANT_BOOT;
            end else if (dbg_pending) begin
               next_state      = S_DBG_ADDR;
               next_last_grant = GRANT_DBG;
            end
         end
         S_BOOT_WR:  next_state = S_CPU;
         S_DBG_ADDR: next_state = S_DBG_DATA;
         S_DBG_DATA: next_state = S_CPU;
         default:    next_state = S_CPU;
      endcase
   end

   always_comb begin
      ram_addr  = cpu_addr[ADDR_W-1:0];
      ram_we    = cpu_we && !boot_en;
      ram_wdata = cpu_wdata;
      boot_ack  = 1'b0;
      cpu_stall = boot_en;
      owner     = owner_of(state_eff);
      case (state_eff)
         S_BOOT_WR: begin
            ram_addr  = boot_addr[ADDR_W-1:0];
            ram_we    = 1'b1;
            ram_wdata = boot_wdata;
            boot_ack  = 1'b1;
            cpu_stall = 1'b1;
         end
         S_DBG_ADDR, S_DBG_DATA: begin
            ram_addr  = dbg_addr[ADDR_W-1:0];
            ram_we    = 1'b0;
            cpu_stall = 1'b1;
         end
         default: ;
      endcase
   end

   assign cpu_rdata = hold_valid ? hold_reg : ram_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dbg_ack       <= 1'b0;
         dbg_rdata     <= '0;
         boot_wr_count <= '0;
         was_cpu       <= 1'b1;
         hold_valid    <= 1'b0;
         hold_reg      <= '0;
      end else begin
         was_cpu <= (state == S_CPU);
         dbg_ack <= (state == S_DBG_DATA);
         if (state == S_DBG_DATA) begin
            dbg_rdata <= ram_rdata;
         end
         if (state == S_BOOT_WR) begin
            boot_wr_count <= boot_wr_count + 16'd1;
         end
         // The RAM output in the first stolen cycle is the CPU's last read.
         if (state != S_CPU && was_cpu) begin
            hold_reg   <= ram_rdata;
            hold_valid <= 1'b1;
         end else if (state == S_CPU) begin
            hold_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-clock arbiter for the 8-bit on-chip program RAM, replacing the `boot_en` address/we/clock muxing in front of it. Three requesters share the one RAM port: the CPU (default owner), the UART bootloader (writes, honoured only in boot mode) and a debug reader (reads, honoured always). The arbiter stalls the CPU while another requester holds the port and preserves any CPU read that was in flight. Everything runs on `clk`, so the RAM no longer switches clocks.

## Interface
- `ADDR_W`, 13: RAM address width; requester addresses are truncated to `[ADDR_W-1:0]`.
- `DATA_W`, 8: data width.

Reset is synchronous and active-low.

- `clk`  in  1  system clock; the RAM and all requesters share it.
- `rst_n`  in  1  synchronous, active-low reset.
- `boot_en`  in  1  boot mode; the CPU is stalled and the bootloader may write.
- `cpu_addr`  in  16  CPU address.
- `cpu_we`  in  1  CPU write enable.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  read data returned to the CPU.
- `cpu_stall`  out  1  CPU must hold its state while this is 1.
- `boot_req`  in  1  bootloader write request; level, held until ack.
- `boot_addr`  in  16  bootloader write address.
- `boot_wdata`  in  DATA_W  bootloader write data.
- `boot_ack`  out  1  write performed this cycle.
- `dbg_req`  in  1  debug read request; level, held until ack.
- `dbg_addr`  in  16  debug read address.
- `dbg_ack`  out  1  one-cycle pulse; `dbg_rdata` is valid.
- `dbg_rdata`  out  DATA_W  registered debug read data; held until the next debug read.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data; synchronous, valid the cycle after the address.
- `owner`  out  2  current port owner: 0 CPU, 1 boot, 2 debug.
- `boot_wr_count`  out  16  number of completed boot writes; drives the HEX display.

## Operation
- FSM states: `S_CPU`, `S_BOOT_WR`, `S_DBG_ADDR`, `S_DBG_DATA`. Reset state is `S_CPU`.
- **`S_CPU`, `boot_en`=0:** the RAM is driven by the CPU signals and `cpu_stall`=0.
- **`S_CPU`, `boot_en`=1:** `ram_we`=0 and `cpu_stall`=1.
- **Arbitration (evaluated only in `S_CPU`):**
  - A request is ignored while its own ack is currently high.
  - With `boot_en`=1 and both requests pending, grants alternate using the `last_grant` bit. `last_grant` resets to debug, so boot wins the first tie.
  - With `boot_en`=0, `boot_req` is ignored and `dbg_req` goes to `S_DBG_ADDR`.
  - With `boot_en`=1, `boot_req` goes to `S_BOOT_WR`.
- **`S_BOOT_WR` (1 cycle):**
  - Drives `ram_addr`=`boot_addr`, `ram_we`=1, `ram_wdata`=`boot_wdata`.
  - `boot_ack`=1 combinationally in this cycle.
  - `boot_wr_count` increments at the end of the cycle, wrapping 0xFFFF→0.
  - Next state is `S_CPU`.
- **`S_DBG_ADDR`:** `ram_addr`=`dbg_addr`, `ram_we`=0. Next state is `S_DBG_DATA`.
- **`S_DBG_DATA`:** at the end of the cycle, `dbg_rdata`←`ram_rdata` and `dbg_ack`←1 (registered). Next state is `S_CPU`.
- **`cpu_stall`:** 1 in every state other than `S_CPU`, and always when `boot_en`=1.
- **CPU read hold:**
  - In the first cycle after leaving `S_CPU`, `hold_reg`←`ram_rdata` (the CPU's in-flight read) and `hold_valid`←1.
  - `cpu_rdata` = `hold_valid ? hold_reg : ram_rdata`.
  - `hold_valid` clears after the first `S_CPU` cycle following the return.
- `boot_en` toggling mid-access does not abort the access in progress.
- `owner` is decoded from the state.

## Timing
- **Reset values:** state `S_CPU`, `boot_ack`=0, `dbg_ack`=0, `dbg_rdata`=0, `boot_wr_count`=0, `hold_valid`=0, `owner`=0.
- **Reset-dependent outputs:** `cpu_stall`=`boot_en`. `ram_*` follow the CPU inputs, with `ram_we`=0 if `boot_en`=1.
- **Boot write:** request sampled at edge N → write and `boot_ack` in cycle N+1. Minimum spacing between writes is 2 cycles.
- **Debug read:** request sampled at edge N → address phase N+1, data phase N+2, `dbg_ack`/`dbg_rdata` in N+3. The CPU loses 2 cycles.
- **Reset mid-access:** the access is abandoned, the RAM is not written after reset asserts, and no ack is issued.

## Structure
- `ram_arbiter_pkg` holds the state enum and the owner codes (`OWN_CPU`=0, `OWN_BOOT`=1, `OWN_DBG`=2).
- No sub-module. Two-way round-robin is inline.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `boot_en`=0 → all reset values above; `ram_addr` tracks `cpu_addr`=0x0123.
- **Boot write:** `boot_en`=1, `boot_req` with addr 0x0042, data 0xA5 → `boot_ack` 1 cycle later; the CPU read of 0x0042 after `boot_en`=0 returns 0xA5; `boot_wr_count`=1.
- **Debug steal:** `boot_en`=0, CPU reading 0x0010 (=0x11) while `dbg_req` is issued for 0x0020 (=0x22) → `cpu_stall` for 2 cycles, `cpu_rdata`=0x11 on release, `dbg_rdata`=0x22 with `dbg_ack` at N+3.
- **Contention:** `boot_en`=1 with `boot_req` and `dbg_req` both held → grants alternate boot, dbg, boot; no request is re-granted while its ack is high.
- **Counter wrap:** preload 0xFFFF boot writes (or force the counter) → the next write gives `boot_wr_count`=0x0000.
- **Reset mid-access:** `rst_n` low during `S_DBG_ADDR` → no `dbg_ack`, `owner`=0 the next cycle.
